icache_fetch_responder: RTL and testbench

//  Responder end of the dual-instruction fetch interface: accepts instruction_req_t

---
 rtl/icache_fetch_responder_if.sv | 44 ++++
 rtl/icache_fetch_responder.sv | 137 +++++++++++++
 tb/tb_icache_fetch_responder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/icache_fetch_responder_if.sv
// Fetch request/response types and the bundle joining the IF stage, the
// I-cache responder and the refill memory port.
package icache_fetch_pkg;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic        p_strobe;
    logic [31:0] instr0_addr;
    logic [31:0] instr1_addr;
  } instruction_req_t;

  typedef struct packed {
    logic [31:0] raw_instr0;
    logic [31:0] raw_instr1;
    logic        instr0_valid;
    logic        instr1_valid;
    logic        ready;
  } instruction_resp_t;

  localparam instruction_resp_t RESP_IDLE  = '{NOP, NOP, 1'b0, 1'b0, 1'b1};
  localparam instruction_resp_t RESP_STALL = '{NOP, NOP, 1'b0, 1'b0, 1'b0};
endpackage

interface icache_fetch_responder_if;
  import icache_fetch_pkg::*;

  instruction_req_t  instruction_req;
  instruction_resp_t instruction_resp;
  logic              invalidate;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [31:0]       mem_req_addr;
  logic              mem_resp_valid;
  logic [31:0]       mem_resp_data;

  modport master (
    output instruction_req, invalidate, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  instruction_resp, mem_req_valid, mem_req_addr
  );
  modport slave (
    input  instruction_req, invalidate, mem_req_ready, mem_resp_valid, mem_resp_data,
    output instruction_resp, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/icache_fetch_responder.sv
// Direct-mapped read-only L1 I-cache answering dual-instruction fetches one
// cycle after the request; misses refill a whole line one word per beat.
module icache_fetch_responder
  import icache_fetch_pkg::*;
#(
  parameter int NUM_LINES  = 64,
  parameter int LINE_WORDS = 8,
  parameter int XLEN       = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  icache_fetch_responder_if.slave bus
);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = XLEN - IW - OW - 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_FILL   = 2'd2;
  localparam logic [1:0] S_RELOOK = 2'd3;

  logic [1:0]                      state;
  logic [NUM_LINES-1:0]            valid_q;
  logic [TW-1:0]                   tag_q  [NUM_LINES];
  logic [LINE_WORDS-1:0][XLEN-1:0] data_q [NUM_LINES];
  logic [IW-1:0]                   fill_idx;
  logic [TW-1:0]                   fill_tag;
  logic [OW-1:0]                   beat;
  logic                            inv_pend;
  logic [XLEN-1:0]                 req_addr_q;
  instruction_resp_t               resp_q;

  logic [XLEN-1:0]                 a0, a1;
  logic [IW-1:0]                   idx;
  logic [TW-1:0]                   tag;
  logic [OW-1:0]                   wo;
  logic [LINE_WORDS-1:0][XLEN-1:0] line;
  logic                            hit, seq, start_fill, last_beat;
  logic [3:0]                      unused_addr_lsb;
  instruction_resp_t               hit_resp;

  assign a0              = bus.instruction_req.instr0_addr;
  assign a1              = bus.instruction_req.instr1_addr;
  assign unused_addr_lsb = {a0[1:0], a1[1:0]};
  assign idx             = a0[OW+2 +: IW];
  assign tag             = a0[XLEN-1 -: TW];
  assign wo              = a0[2 +: OW];
  assign line            = data_q[idx];
  assign hit             = valid_q[idx] && (tag_q[idx] == tag);
  // instr1 rides on the same lookup only if it is the next word in this line
  assign seq = (a1[XLEN-1:2] == a0[XLEN-1:2] + (XLEN-2)'(1)) && (wo != OW'(LINE_WORDS-1));
  assign last_beat = bus.mem_resp_valid && (beat == OW'(LINE_WORDS-1));

  always_comb begin
    hit_resp              = RESP_IDLE;
    hit_resp.raw_instr0   = line[wo];
    hit_resp.raw_instr1   = seq ? line[wo + OW'(1)] : NOP;
    hit_resp.instr0_valid = 1'b1;
    hit_resp.instr1_valid = seq;
  end

  // an invalidate sampled with the request forces that request to miss
  always_comb begin
    start_fill = 1'b0;
    if (state == S_IDLE)
      start_fill = bus.instruction_req.p_strobe && !(hit && !bus.invalidate);
    else if (state == S_RELOOK)
      start_fill = !hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      valid_q    <= '0;
      fill_idx   <= '0;
      fill_tag   <= '0;
      beat       <= '0;
      inv_pend   <= 1'b0;
      req_addr_q <= '0;
      resp_q     <= RESP_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.invalidate) valid_q <= '0;
          if (!bus.instruction_req.p_strobe) resp_q <= RESP_IDLE;
          else if (!start_fill)              resp_q <= hit_resp;
        end
        S_REQ: begin
          inv_pend <= inv_pend | bus.invalidate;
          if (bus.mem_req_ready) begin
            state <= S_FILL;
            beat  <= '0;
          end
        end
        S_FILL: begin
          inv_pend <= inv_pend | bus.invalidate;
          if (bus.mem_resp_valid) beat <= beat + OW'(1);
          if (last_beat) begin
            valid_q[fill_idx] <= 1'b1;
            state             <= S_RELOOK;
          end
        end
        default: begin
          if (hit) begin
            resp_q   <= hit_resp;
            state    <= S_IDLE;
            inv_pend <= 1'b0;
            if (inv_pend || bus.invalidate) valid_q <= '0;
          end else begin
            inv_pend <= inv_pend | bus.invalidate;
          end
        end
      endcase
      if (start_fill) begin
        state        <= S_REQ;
        resp_q       <= RESP_STALL;
        fill_idx     <= idx;
        fill_tag     <= tag;
        req_addr_q   <= {tag, idx, {(OW+2){1'b0}}};
        valid_q[idx] <= 1'b0;
      end
    end
  end

  // line storage has no reset; the valid bits alone decide hits
  always_ff @(posedge clk) begin
    if (state == S_FILL && bus.mem_resp_valid) begin
      data_q[fill_idx][beat] <= bus.mem_resp_data;
      if (last_beat) tag_q[fill_idx] <= fill_tag;
    end
  end

  assign bus.instruction_resp = resp_q;
  assign bus.mem_req_valid    = (state == S_REQ);
  assign bus.mem_req_addr     = req_addr_q;
endmodule

// File: tb/tb_icache_fetch_responder.sv
// Directed + randomized fetches against a line-level cache model; memory
// contents are a fixed function of the word address.
module tb_icache_fetch_responder;
  import icache_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  icache_fetch_responder_if bus ();

  icache_fetch_responder #(.NUM_LINES(64), .LINE_WORDS(8), .XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          total = 0;
  int          bad = 0;
  bit          mvalid [64];
  logic [20:0] mtag   [64];
  bit          mpend;
  logic [31:0] cur0, cur1;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a << 5) ^ 32'h13 ^ (a >> 16);
  endfunction

  function automatic bit mhit(input logic [31:0] a);
    return mvalid[a[10:5]] && (mtag[a[10:5]] == a[31:11]);
  endfunction

  task automatic mclear();
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
  endtask

  task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", t, obs, exp);
    end
  endtask

  task automatic check_hit(input logic [31:0] a0, input logic [31:0] a1);
    logic [31:0] w0;
    bit          sq;
    w0 = a0 & ~32'h3;
    sq = (a1[31:2] == a0[31:2] + 30'd1) && (a0[4:2] != 3'd7);
    chk("hit_ready", bus.instruction_resp.ready, 1);
    chk("hit_v0",    bus.instruction_resp.instr0_valid, 1);
    chk("hit_raw0",  bus.instruction_resp.raw_instr0, memword(w0));
    chk("hit_v1",    bus.instruction_resp.instr1_valid, sq);
    chk("hit_raw1",  bus.instruction_resp.raw_instr1, sq ? memword(w0 + 32'd4) : NOP);
  endtask

  task automatic check_idle(input string t);
    chk({t, "_ready"}, bus.instruction_resp.ready, 1);
    chk({t, "_v0"},    bus.instruction_resp.instr0_valid, 0);
    chk({t, "_v1"},    bus.instruction_resp.instr1_valid, 0);
    chk({t, "_raw0"},  bus.instruction_resp.raw_instr0, NOP);
    chk({t, "_mreq"},  bus.mem_req_valid, 0);
  endtask

  // Called one #1 after the edge that put the DUT into REQ.
  task automatic serve(input bit do_redir, input logic [31:0] r0, input logic [31:0] r1,
                       input bit do_inv);
    logic [31:0] ln;
    ln = {cur0[31:5], 5'b0};
    chk("req_valid", bus.mem_req_valid, 1);
    chk("req_addr",  bus.mem_req_addr, ln);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    chk("req_hold", bus.mem_req_valid, 1);
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    chk("req_drop", bus.mem_req_valid, 0);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = memword(ln + 32'(i * 4));
      if (do_redir && i == 3) begin
        cur0 = r0;
        cur1 = r1;
        bus.instruction_req.instr0_addr = r0;
        bus.instruction_req.instr1_addr = r1;
      end
      if (do_inv && i == 4) begin
        bus.invalidate = 1'b1;
        mpend = 1'b1;
      end
      @(posedge clk); #1;
      bus.mem_resp_valid = 1'b0;
      bus.invalidate     = 1'b0;
    end
    chk("fill_stall", bus.instruction_resp.ready, 0);
    mvalid[ln[10:5]] = 1'b1;
    mtag[ln[10:5]]   = ln[31:11];
  endtask

  task automatic fetch(input logic [31:0] a0, input logic [31:0] a1, input bit inv_now,
                       input bit redir, input logic [31:0] r0, input logic [31:0] r1,
                       input bit inv_fill);
    bit done;
    bus.instruction_req = '{1'b1, a0, a1};
    bus.invalidate      = inv_now;
    if (inv_now) mclear();
    cur0 = a0;
    cur1 = a1;
    @(posedge clk); #1;
    bus.invalidate = 1'b0;
    if (mhit(cur0)) begin
      check_hit(cur0, cur1);
      chk("hit_no_mreq", bus.mem_req_valid, 0);
    end else begin
      chk("miss_ready", bus.instruction_resp.ready, 0);
      chk("miss_v0",    bus.instruction_resp.instr0_valid, 0);
      done = 1'b0;
      for (int g = 0; g < 4 && !done; g++) begin
        serve(g == 0 && redir, r0, r1, g == 0 && inv_fill);
        @(posedge clk); #1;
        if (mhit(cur0)) begin
          check_hit(cur0, cur1);
          done = 1'b1;
          if (mpend) mclear();
          mpend = 1'b0;
        end else begin
          chk("relook_miss_ready", bus.instruction_resp.ready, 0);
        end
      end
      if (!done) chk("relook_timeout", 0, 1);
    end
    bus.instruction_req.p_strobe = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    return (32'($urandom_range(0, 2)) << 11) | (32'($urandom_range(0, 3)) << 5) |
           (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [31:0] ra0, ra1, rr0;
    bus.instruction_req = '0;
    bus.invalidate      = 1'b0;
    bus.mem_req_ready   = 1'b0;
    bus.mem_resp_valid  = 1'b0;
    bus.mem_resp_data   = '0;
    mclear();
    mpend = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_idle("rst");
    chk("rst_v1",    bus.instruction_resp.instr1_valid, 0);
    chk("rst_raw1",  bus.instruction_resp.raw_instr1, NOP);
    chk("rst_maddr", bus.mem_req_addr, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("idle0");

    fetch(32'h0, 32'h4, 0, 0, 0, 0, 0);                 // cold
    fetch(32'h8, 32'hC, 0, 0, 0, 0, 0);                 // warm
    @(posedge clk); #1;
    check_idle("nostrobe");
    fetch(32'h1C, 32'h20, 0, 0, 0, 0, 0);               // line edge
    fetch(32'h800, 32'h804, 0, 0, 0, 0, 0);             // conflict
    fetch(32'h0, 32'h4, 0, 0, 0, 0, 0);
    fetch(32'h800, 32'h804, 0, 0, 0, 0, 0);
    fetch(32'h0, 32'h4, 0, 1, 32'h40, 32'h44, 0);       // redirect during fill
    fetch(32'h40, 32'h44, 1, 0, 0, 0, 0);               // invalidate with request
    fetch(32'h100, 32'h104, 0, 0, 0, 0, 1);             // invalidate during fill
    fetch(32'h40, 32'h44, 0, 0, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      ra0 = rand_addr();
      case ($urandom_range(0, 3))
        0: ra1 = ra0 + 32'd4;
        1: ra1 = ra0 + 32'd8;
        2: ra1 = (ra0 & ~32'h3) + 32'd7;
        default: ra1 = rand_addr();
      endcase
      rr0 = rand_addr();
      fetch(ra0, ra1, $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
            rr0, rr0 + 32'd4, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        check_idle("rand_idle");
      end
    end

    // invalidate during fill, then reset mid-beat
    bus.instruction_req = '{1'b1, 32'h200, 32'h204};
    @(posedge clk); #1;
    bus.instruction_req.p_strobe = 1'b0;
    chk("t6_miss", bus.instruction_resp.ready, 0);
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = memword(32'h200 + 32'(i * 4));
      bus.invalidate     = (i == 3);
      @(posedge clk); #1;
    end
    bus.invalidate    = 1'b0;
    bus.mem_resp_data = 32'hBAD0_0000;
    #2 rst_n = 1'b0;
    #1;
    check_idle("t6_rst");
    chk("t6_maddr", bus.mem_req_addr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check_idle("t6_late");
    end
    bus.mem_resp_valid = 1'b0;
    mclear();
    mpend = 1'b0;
    fetch(32'h0, 32'h4, 0, 0, 0, 0, 0);
    fetch(32'h200, 32'h204, 0, 0, 0, 0, 0);
    fetch(32'h208, 32'h20C, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
